fetch_unit: RTL and testbench

Instruction fetch stage: the producing end of the IF/ID pipeline interface that the decoder consumes. It fetches one 32-bit instruction per cycle over a simple request/ready instruction-memory port and drives `if_pc`, `if_insn` and `if_en` into the ID stage. It handles wait states, pipeline stall, branch redirect and exception flush, and has a one-entry skid buffer so a word that returns during a stall is not lost.

---
 rtl/fetch_unit_pkg.sv | 33 +++
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_pipe_reg.sv | 37 +++
 rtl/fetch_unit.sv | 145 ++++++++++++++
 tb/tb_fetch_unit.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared widths, encodings and IF/ID bundle for the fetch stage.
// Imported by the interface, the IF/ID register and the fetch unit.
package fetch_unit_pkg;

  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [WORD_DATA_W-1:0] ISA_NOP = 32'h0000_0000;

  typedef logic [WORD_ADDR_W-1:0] waddr_t;
  typedef logic [WORD_DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    FETCH_ST_IDLE  = 2'd0,
    FETCH_ST_FETCH = 2'd1,
    FETCH_ST_DRAIN = 2'd2,
    FETCH_ST_FULL  = 2'd3
  } fetch_st_e;

  typedef struct packed {
    waddr_t pc;
    word_t  insn;
    logic   en;
  } if_id_t;

  function automatic waddr_t pc_inc(input waddr_t pc);
    return pc + waddr_t'(1);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port of the fetch stage.
// The fetch unit is the master; memory is the slave.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic   bus_req;
  waddr_t bus_addr;
  word_t  bus_rd_data;
  logic   bus_rdy;

  modport master (
    output bus_req,
    output bus_addr,
    input  bus_rd_data,
    input  bus_rdy
  );

  modport slave (
    input  bus_req,
    input  bus_addr,
    output bus_rd_data,
    output bus_rdy
  );

endinterface

// File: rtl/fetch_pipe_reg.sv
// IF/ID pipeline register with flush, hold and load controls.
// Flush wins over hold, hold wins over load.
module fetch_pipe_reg
  import fetch_unit_pkg::*;
#(
  parameter word_t NOP_INSN = ISA_NOP
) (
  input  logic   clk,
  input  logic   reset_,
  input  logic   flush_i,
  input  logic   hold_i,
  input  logic   load_i,
  input  waddr_t pc_i,
  input  word_t  insn_i,
  output if_id_t if_id_o
);

  if_id_t q;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      q.pc   <= '0;
      q.insn <= NOP_INSN;
      q.en   <= DISABLE;
    end else if (flush_i) begin
      q.insn <= NOP_INSN;
      q.en   <= DISABLE;
    end else if (!hold_i && load_i) begin
      q.pc   <= pc_i;
      q.insn <= insn_i;
      q.en   <= ENABLE;
    end
  end

  assign if_id_o = q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, request FSM, one-entry skid buffer.
// Drives the IF/ID register consumed by the decoder.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter waddr_t RESET_VECTOR = '0,
  parameter word_t  NOP_INSN     = ISA_NOP
) (
  input  logic   clk,
  input  logic   reset_,
  input  logic   stall,
  input  logic   flush,
  input  waddr_t new_pc,
  input  logic   br_taken,
  input  waddr_t br_addr,
  fetch_unit_if.master bus,
  output waddr_t if_pc,
  output word_t  if_insn,
  output logic   if_en
);

  fetch_st_e state_q;
  waddr_t    pc_q;
  waddr_t    drain_q;
  word_t     buf_insn_q;
  waddr_t    buf_pc_q;

  logic   redirect;
  waddr_t redir_pc_d;
  logic   rdy;

  logic   pr_flush;
  logic   pr_hold;
  logic   pr_load;
  waddr_t pr_pc;
  word_t  pr_insn;
  if_id_t if_id;

  // A branch from a stalled ID is not yet resolved, so only flush beats stall.
  assign redirect   = flush | (br_taken & ~stall);
  assign redir_pc_d = flush ? new_pc : br_addr;
  assign rdy        = bus.bus_rdy;

  assign bus.bus_req  = (state_q == FETCH_ST_FETCH) ||
                        (state_q == FETCH_ST_DRAIN);
  assign bus.bus_addr = (state_q == FETCH_ST_DRAIN) ? drain_q : pc_q;

  always_comb begin
    pr_flush = DISABLE;
    pr_hold  = DISABLE;
    pr_load  = DISABLE;
    pr_pc    = pc_q;
    pr_insn  = bus.bus_rd_data;
    unique case (state_q)
      FETCH_ST_IDLE: begin
        pr_flush = redirect;
        pr_hold  = ~redirect;
      end
      FETCH_ST_FETCH: begin
        if (redirect)   pr_flush = ENABLE;
        else if (stall) pr_hold  = ENABLE;
        else if (rdy)   pr_load  = ENABLE;
        else            pr_flush = ENABLE;
      end
      FETCH_ST_DRAIN: begin
        pr_flush = ENABLE;
      end
      FETCH_ST_FULL: begin
        pr_pc   = buf_pc_q;
        pr_insn = buf_insn_q;
        if (redirect)   pr_flush = ENABLE;
        else if (stall) pr_hold  = ENABLE;
        else            pr_load  = ENABLE;
      end
      default: pr_hold = ENABLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q    <= FETCH_ST_IDLE;
      pc_q       <= RESET_VECTOR;
      drain_q    <= '0;
      buf_insn_q <= NOP_INSN;
      buf_pc_q   <= '0;
    end else begin
      unique case (state_q)
        FETCH_ST_IDLE: begin
          state_q <= FETCH_ST_FETCH;
          if (redirect) pc_q <= redir_pc_d;
        end
        FETCH_ST_FETCH: begin
          if (redirect) begin
            pc_q <= redir_pc_d;
            // An unfinished request must still complete on the bus.
            if (!rdy) begin
              drain_q <= pc_q;
              state_q <= FETCH_ST_DRAIN;
            end
          end else if (stall) begin
            if (rdy) begin
              buf_insn_q <= bus.bus_rd_data;
              buf_pc_q   <= pc_q;
              pc_q       <= pc_inc(pc_q);
              state_q    <= FETCH_ST_FULL;
            end
          end else if (rdy) begin
            pc_q <= pc_inc(pc_q);
          end
        end
        FETCH_ST_DRAIN: begin
          if (flush) pc_q <= new_pc;
          if (rdy) state_q <= FETCH_ST_FETCH;
        end
        FETCH_ST_FULL: begin
          if (redirect) begin
            pc_q    <= redir_pc_d;
            state_q <= FETCH_ST_FETCH;
          end else if (!stall) begin
            state_q <= FETCH_ST_FETCH;
          end
        end
        default: state_q <= FETCH_ST_IDLE;
      endcase
    end
  end

  fetch_pipe_reg #(
    .NOP_INSN (NOP_INSN)
  ) u_pipe (
    .clk     (clk),
    .reset_  (reset_),
    .flush_i (pr_flush),
    .hold_i  (pr_hold),
    .load_i  (pr_load),
    .pc_i    (pr_pc),
    .insn_i  (pr_insn),
    .if_id_o (if_id)
  );

  assign if_pc   = if_id.pc;
  assign if_insn = if_id.insn;
  assign if_en   = if_id.en;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed bus/stall/redirect stimulus,
// a monitor pops expected PCs whenever ID would consume a valid word.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam word_t NOP = 32'h0000_0013;

  logic   clk      = 1'b0;
  logic   reset_   = 1'b0;
  logic   stall    = 1'b0;
  logic   flush    = 1'b0;
  logic   br_taken = 1'b0;
  waddr_t new_pc   = '0;
  waddr_t br_addr  = '0;
  waddr_t if_pc;
  word_t  if_insn;
  logic   if_en;

  int     n_chk  = 0;
  int     n_pass = 0;
  bit     done   = 1'b0;
  waddr_t exp_q[$];

  always #5 clk = ~clk;

  fetch_unit_if bus();

  function automatic word_t mem(input waddr_t a);
    return 32'hA000_0000 + {2'b00, a};
  endfunction

  assign bus.bus_rd_data = mem(bus.bus_addr);

  fetch_unit #(
    .RESET_VECTOR (30'h0),
    .NOP_INSN     (NOP)
  ) dut (
    .clk      (clk),
    .reset_   (reset_),
    .stall    (stall),
    .flush    (flush),
    .new_pc   (new_pc),
    .br_taken (br_taken),
    .br_addr  (br_addr),
    .bus      (bus.master),
    .if_pc    (if_pc),
    .if_insn  (if_insn),
    .if_en    (if_en)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic push(input waddr_t a);
    exp_q.push_back(a);
  endtask

  // Monitor: ID consumes IF/ID when if_en=1 and stall=0.
  initial begin
    waddr_t e;
    while (!done) begin
      @(negedge clk);
      if (reset_ && if_en && !stall) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_word: got pc %h want none", if_pc);
        end else begin
          e = exp_q.pop_front();
          chk("mon_pc", 32'(if_pc), 32'(e));
          chk("mon_insn", if_insn, mem(e));
        end
      end else if (!if_en) begin
        chk("bubble_nop", if_insn, NOP);
      end
    end
  end

  initial begin
    bus.bus_rdy = 1'b1;
    tick;
    tick;
    chk("rst_req", 32'(bus.bus_req), 32'h0);
    chk("rst_addr", 32'(bus.bus_addr), 32'h0);
    chk("rst_en", 32'(if_en), 32'h0);
    chk("rst_pc", 32'(if_pc), 32'h0);
    chk("rst_insn", if_insn, NOP);

    for (int i = 0; i < 5; i++) push(30'(i));
    reset_ = 1'b1;
    tick;
    chk("first_req", 32'(bus.bus_req), 32'h1);
    chk("first_addr", 32'(bus.bus_addr), 32'h0);
    repeat (5) tick;
    chk("stream_pc", 32'(if_pc), 32'h4);
    chk("stream_addr", 32'(bus.bus_addr), 32'h5);

    bus.bus_rdy = 1'b0;
    tick;
    chk("wait_addr1", 32'(bus.bus_addr), 32'h5);
    chk("wait_en1", 32'(if_en), 32'h0);
    tick;
    chk("wait_addr2", 32'(bus.bus_addr), 32'h5);
    chk("wait_en2", 32'(if_en), 32'h0);
    push(30'h5); push(30'h6); push(30'h7);
    bus.bus_rdy = 1'b1;
    tick;
    chk("wait_done_pc", 32'(if_pc), 32'h5);
    tick;
    tick;
    chk("pre_stall_addr", 32'(bus.bus_addr), 32'h8);

    stall = 1'b1;
    tick;
    chk("full_req", 32'(bus.bus_req), 32'h0);
    chk("full_hold_pc", 32'(if_pc), 32'h7);
    tick;
    tick;
    chk("full_hold_en", 32'(if_en), 32'h1);
    chk("full_req2", 32'(bus.bus_req), 32'h0);
    for (int i = 8; i < 12; i++) push(30'(i));
    stall = 1'b0;
    tick;
    chk("skid_pc", 32'(if_pc), 32'h8);
    chk("after_full_addr", 32'(bus.bus_addr), 32'h9);
    repeat (3) tick;
    chk("pre_br_addr", 32'(bus.bus_addr), 32'hC);

    bus.bus_rdy = 1'b0;
    tick;
    br_taken = 1'b1;
    br_addr  = 30'h40;
    tick;
    br_taken = 1'b0;
    chk("drain_addr", 32'(bus.bus_addr), 32'hC);
    chk("drain_req", 32'(bus.bus_req), 32'h1);
    chk("drain_en", 32'(if_en), 32'h0);
    tick;
    chk("drain_addr2", 32'(bus.bus_addr), 32'hC);
    push(30'h40);
    bus.bus_rdy = 1'b1;
    tick;
    chk("br_target_addr", 32'(bus.bus_addr), 32'h40);
    tick;
    chk("br_target_pc", 32'(if_pc), 32'h40);

    br_taken = 1'b1;
    br_addr  = 30'h80;
    tick;
    br_taken = 1'b0;
    chk("zw_br_addr", 32'(bus.bus_addr), 32'h80);
    chk("zw_br_en", 32'(if_en), 32'h0);
    tick;
    chk("zw_br_pc", 32'(if_pc), 32'h80);

    stall = 1'b1;
    tick;
    chk("full2_req", 32'(bus.bus_req), 32'h0);
    chk("full2_en", 32'(if_en), 32'h1);
    flush  = 1'b1;
    new_pc = 30'h100;
    tick;
    flush = 1'b0;
    stall = 1'b0;
    chk("flush_en", 32'(if_en), 32'h0);
    chk("flush_addr", 32'(bus.bus_addr), 32'h100);
    chk("flush_req", 32'(bus.bus_req), 32'h1);
    push(30'h100);
    tick;
    chk("flush_pc", 32'(if_pc), 32'h100);

    flush  = 1'b1;
    new_pc = 30'h3FFF_FFFF;
    tick;
    flush = 1'b0;
    chk("wrap_top_addr", 32'(bus.bus_addr), 32'h3FFF_FFFF);
    push(30'h3FFF_FFFF);
    push(30'h0);
    tick;
    chk("wrap_addr", 32'(bus.bus_addr), 32'h0);
    tick;
    bus.bus_rdy = 1'b0;
    tick;
    chk("mid_wait_req", 32'(bus.bus_req), 32'h1);
    chk("mid_wait_addr", 32'(bus.bus_addr), 32'h1);
    reset_ = 1'b0;
    #1;
    chk("async_req_drop", 32'(bus.bus_req), 32'h0);
    chk("async_addr", 32'(bus.bus_addr), 32'h0);
    chk("async_en", 32'(if_en), 32'h0);
    tick;
    reset_ = 1'b1;
    bus.bus_rdy = 1'b1;
    push(30'h0);
    tick;
    chk("rst2_addr", 32'(bus.bus_addr), 32'h0);
    chk("rst2_req", 32'(bus.bus_req), 32'h1);
    tick;
    chk("rst2_pc", 32'(if_pc), 32'h0);
    bus.bus_rdy = 1'b0;
    tick;
    tick;
    done = 1'b1;
    @(negedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
